// File: rtl/noc_inport_requester.sv
// Input-port front end of a NoC router: a flit FIFO followed by a packet
// framer that requests the crossbar from the port arbiter and streams the
// buffered packet out while the grant is held.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no packet owned; orphan flits at the head are discarded
// REQ    | header at head, req raised, waiting for (re)grant
// XFER   | grant held, head flits streamed to the crossbar
module noc_inport_requester #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_flit_id,
  input  logic [11:0]       in_length,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [7:0]        drop_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam logic [2:0] ID_HEAD = 3'b001;
  localparam logic [2:0] ID_TAIL = 3'b100;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [2:0]        mem_id   [DEPTH];
  logic [11:0]       mem_len  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop_inc;
  logic        len_load;
  logic [2:0]  head_id;
  logic [11:0] head_len;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  // Gated by rst so upstream sees back-pressure for the whole reset period.
  assign in_ready = rst & ~full;
  assign push     = in_valid & in_ready;

  assign head_id  = mem_id[rd_ptr];
  assign head_len = mem_len[rd_ptr];
  assign flit_id  = empty ? 3'b000 : head_id;
  assign out_data = mem_data[rd_ptr];

  // Grant loss must silence the crossbar in the same cycle, hence combinational.
  assign out_valid = (state == ST_XFER) & grant & ~empty;

  // Storage array: written on push only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_id[wr_ptr]   <= in_flit_id;
      mem_len[wr_ptr]  <= in_length;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state, pop, drop and length-capture decisions.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drop_inc  = 1'b0;
    len_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (head_id == ID_HEAD) begin
            len_load  = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            pop      = 1'b1;
            drop_inc = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (grant) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (!grant) begin
          state_nxt = ST_REQ;
        end else if (out_valid && out_ready) begin
          pop = 1'b1;
          if (head_id == ID_TAIL) begin
            state_nxt = ST_IDLE;
          end else if (head_id == ID_HEAD) begin
            // A header arriving without a preceding tail closes the old
            // packet and opens a new one under the same grant.
            len_load = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, registered request, latched length and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req      <= 1'b0;
      length   <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt != ST_IDLE);
      if (len_load) length <= head_len;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_noc_inport_requester.sv
// Randomised and directed bench for noc_inport_requester, compared cycle by
// cycle against a queue-based packet-ownership model.
module tb_noc_inport_requester;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [2:0]  id;
    logic [11:0] len;
    logic [31:0] data;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [2:0]  in_flit_id = '0;
  logic [11:0] in_length = '0;
  logic        grant = 1'b0;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [7:0]  drop_cnt;

  noc_inport_requester #(.DATA_W(32), .DEPTH(DEPTH), .AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_flit_id (in_flit_id),
    .in_length  (in_length),
    .grant      (grant),
    .req        (req),
    .flit_id    (flit_id),
    .length     (length),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: buffered flits, ownership mode (0 none, 1 waiting for grant,
  // 2 streaming), latched length and discarded-flit count.
  flit_t mq[$];
  flit_t src[$];
  int    mode = 0;
  int    mlen = 0;
  int    mdrop = 0;
  int    n_out = 0;
  bit    acc_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mode  = 0;
    mlen  = 0;
    mdrop = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit v, input logic [2:0] id, input logic [11:0] ln,
                      input logic [31:0] d, input bit g, input bit ordy, output bit acc);
    flit_t h;
    bit    emp;
    bit    ov;
    bit    pop;
    @(negedge clk);
    in_valid   = v;
    in_flit_id = id;
    in_length  = ln;
    in_data    = d;
    grant      = g;
    out_ready  = ordy;
    #1;
    emp = (mq.size() == 0);
    h   = emp ? flit_t'('0) : mq[0];
    ov  = (mode == 2) && g && !emp;
    chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    chk("req",       32'(req),       32'(mode != 0));
    chk("flit_id",   32'(flit_id),   emp ? 32'd0 : 32'(h.id));
    chk("out_valid", 32'(out_valid), 32'(ov));
    if (ov) chk("out_data", out_data, h.data);
    chk("length",    32'(length),    32'(mlen));
    chk("drop_cnt",  32'(drop_cnt),  32'(mdrop));

    acc = v && (mq.size() < DEPTH);
    pop = 1'b0;
    if (mode == 0) begin
      if (!emp) begin
        if (h.id == 3'b001) begin
          mlen = int'(h.len);
          mode = 1;
        end else begin
          pop = 1'b1;
          if (mdrop < 255) mdrop++;
        end
      end
    end else if (mode == 1) begin
      if (g) mode = 2;
    end else begin
      if (!g) mode = 1;
      else if (ov && ordy) begin
        pop = 1'b1;
        n_out++;
        if (h.id == 3'b100) mode = 0;
        else if (h.id == 3'b001) mlen = int'(h.len);
      end
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{id: id, len: ln, data: d});
  endtask

  task automatic idle(input int n, input bit g, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 12'd0, 32'd0, g, ordy, acc_d);
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_req",       32'(req),       32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_flit_id",   32'(flit_id),   32'd0);
    chk("rst_length",    32'(length),    32'd0);
    model_clear();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int start_out;
    int budget;
    bit g_r;

    // Power-on reset.
    repeat (2) @(negedge clk);
    chk("por_req",       32'(req),       32'd0);
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_in_ready",  32'(in_ready),  32'd0);
    chk("por_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("por_flit_id",   32'(flit_id),   32'd0);
    #2 rst = 1'b1;
    idle(2, 1'b0, 1'b0);

    // Three-flit packet buffered with no grant, then streamed.
    step(1'b1, 3'b001, 12'd3, 32'hA000_0001, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b010, 12'd0, 32'hA000_0002, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b100, 12'd0, 32'hA000_0003, 1'b0, 1'b1, acc_d);
    idle(2, 1'b0, 1'b1);
    chk("pkt3_req",    32'(req),    32'd1);
    chk("pkt3_length", 32'(length), 32'd3);
    start_out = n_out;
    idle(6, 1'b1, 1'b1);
    chk("pkt3_out_count", 32'(n_out - start_out), 32'd3);
    chk("pkt3_req_low",   32'(req),               32'd0);

    // Orphans with no header are discarded.
    step(1'b1, 3'b010, 12'd0, 32'hB000_0001, 1'b0, 1'b0, acc_d);
    step(1'b1, 3'b100, 12'd0, 32'hB000_0002, 1'b0, 1'b0, acc_d);
    idle(3, 1'b0, 1'b0);
    chk("orphan_drop", 32'(drop_cnt), 32'd2);
    chk("orphan_req",  32'(req),      32'd0);

    // Four-flit packet with grant withdrawn after two flits.
    step(1'b1, 3'b001, 12'd4, 32'hC000_0001, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b010, 12'd0, 32'hC000_0002, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b010, 12'd0, 32'hC000_0003, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b100, 12'd0, 32'hC000_0004, 1'b0, 1'b1, acc_d);
    start_out = n_out;
    idle(3, 1'b1, 1'b1);
    chk("pkt4_first_two", 32'(n_out - start_out), 32'd2);
    idle(5, 1'b0, 1'b1);
    chk("pkt4_req_held", 32'(req), 32'd1);
    idle(5, 1'b1, 1'b1);
    chk("pkt4_total", 32'(n_out - start_out), 32'd4);

    // Fill the FIFO without grant, then free one slot.
    step(1'b1, 3'b001, 12'd8, 32'hD000_0000, 1'b0, 1'b0, acc_d);
    for (int i = 1; i < 8; i++)
      step(1'b1, 3'b010, 12'd0, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, acc_d);
    idle(1, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    idle(2, 1'b1, 1'b1);
    step(1'b1, 3'b100, 12'd0, 32'hD000_0008, 1'b1, 1'b1, acc_d);
    idle(12, 1'b1, 1'b1);

    // Drive the drop counter into saturation.
    for (int i = 0; i < 300; i++)
      step(1'b1, 3'b010, 12'd0, $urandom, 1'b0, 1'b0, acc_d);
    idle(2, 1'b0, 1'b0);
    chk("drop_saturated", 32'(drop_cnt), 32'd255);
    async_reset();
    idle(2, 1'b0, 1'b0);

    // Randomised packet stream.
    for (int p = 0; p < 250; p++) begin
      int r;
      int n;
      r = int'($urandom % 10);
      if (r == 0) src.push_back('{id: 3'b010, len: 12'd0, data: $urandom});
      else if (r == 1) src.push_back('{id: 3'b011, len: 12'd0, data: $urandom});
      else begin
        n = 2 + int'($urandom % 4);
        src.push_back('{id: 3'b001, len: 12'(n), data: $urandom});
        for (int b = 0; b < n - 2; b++) src.push_back('{id: 3'b010, len: 12'd0, data: $urandom});
        if (r != 2) src.push_back('{id: 3'b100, len: 12'd0, data: $urandom});
      end
    end
    g_r = 1'b0;
    budget = 0;
    while (src.size() > 0 && budget < 6000) begin
      bit v;
      bit acc;
      if ($urandom % 8 == 0) g_r = ~g_r;
      v = ($urandom % 4) != 0;
      step(v, src[0].id, src[0].len, src[0].data, g_r, ($urandom % 4) != 0, acc);
      if (acc) void'(src.pop_front());
      budget++;
    end
    chk("random_stream_consumed", 32'(src.size()), 32'd0);
    idle(40, 1'b1, 1'b1);

    // Reset in the middle of a granted transfer.
    step(1'b1, 3'b001, 12'd4, 32'hE000_0001, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b010, 12'd0, 32'hE000_0002, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b010, 12'd0, 32'hE000_0003, 1'b0, 1'b1, acc_d);
    step(1'b1, 3'b100, 12'd0, 32'hE000_0004, 1'b0, 1'b1, acc_d);
    idle(2, 1'b1, 1'b1);
    chk("mid_xfer_out_valid", 32'(out_valid), 32'd1);
    async_reset();
    idle(3, 1'b1, 1'b1);
    chk("post_reset_empty", 32'(flit_id), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/noc_inport_requester.md
Name: noc_inport_requester

Overview:
Input-port front end of a NoC router; the requesting side of the port arbiter protocol. It buffers incoming flits in a FIFO and frames them into packets. It raises a per-port request with header flit_id and packet length toward the arbiter, then streams the packet out while the grant is held. One instance sits on each of the L/N/E/W/S ports and drives that port's req, flit_id and length arbiter inputs.

Parameters:
DATA_W, 32, flit payload width
DEPTH, 8, FIFO entries (power of two, >=2)
AW, 3, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
in_valid  input  1  upstream flit valid
in_ready  output  1  FIFO can accept (not full)
in_data  input  DATA_W  upstream flit payload
in_flit_id  input  3  001 header, 010 body, 100 tail; others invalid
in_length  input  12  packet length in flits, sampled with header only
grant  input  1  this port currently owns the crossbar (arbiter state bit)
req  output  1  request to arbiter
flit_id  output  3  flit_id of head flit, to arbiter timer
length  output  12  length of current packet, to arbiter timer
out_valid  output  1  flit presented to crossbar
out_data  output  DATA_W  head flit payload
out_ready  input  1  crossbar/downstream accepts
drop_cnt  output  8  count of discarded orphan flits, saturating

Behaviour:
- Reset (rst=0, async): FIFO empty, pointers 0, state IDLE; req=0, out_valid=0, flit_id=000, length=0, drop_cnt=0, in_ready=0 while in reset.
- FIFO: stores {flit_id, length, data}. Write when in_valid&in_ready. Read on pop. Simultaneous push and pop while full is disallowed: in_ready=0 when full, with no look-ahead. Push and pop while empty: the new flit is not visible until the next cycle, with no bypass. Occupancy counter is AW+1 bits.
- flit_id/out_data always reflect the FIFO head; flit_id=000 when empty.
- State machine:
  IDLE: head empty -> stay. Head is a header -> latch length from head, go REQ. Head is non-header -> pop and discard, drop_cnt+1 (saturate at 255), stay IDLE.
  REQ: req=1. grant=1 -> XFER.
  XFER: req=1. out_valid = grant & head non-empty. Pop on out_valid&out_ready. Popped flit is tail -> req falls the next cycle, go IDLE. Popped flit is header (back-to-back header, no tail) -> treated as the end of the previous packet, new length latched, stay XFER. grant drops mid-packet (arbiter timeout) -> out_valid=0 the same cycle, go REQ holding req=1; the packet resumes on re-grant, with no flit lost or duplicated.
- req is registered and changes only on a clock edge. out_valid is combinational from grant and the FIFO state.
- length holds its value until the next header is latched.
- A header+tail of the same packet may both be resident; the FIFO never reorders.
- Reset mid-packet: all state is cleared immediately and buffered flits are lost.

Test Plan:
- Reset, then push header(len=3),body,tail with grant held 0 -> req=1 after the header reaches the head, length=3, flit_id=001, out_valid=0.
- Same, then raise grant=1 with out_ready=1 -> three flits out on consecutive cycles with flit_id 001,010,100; req=0 one cycle after the tail; state IDLE.
- Push body,tail with no header -> both discarded, drop_cnt=2, req never asserted.
- Header(len=4),body,body,tail; drop grant after 2 flits, re-grant 5 cycles later -> req stays 1 throughout, remaining 2 flits delivered in order, total 4 out.
- Fill 8 flits with no grant -> in_ready=0; one pop with grant&out_ready -> in_ready=1 next cycle.
- Assert rst=0 asynchronously mid-transfer -> req, out_valid and drop_cnt go 0 without a clock edge; FIFO is empty after release.
